// File: rtl/du_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : du_regfile_dump
// Description : Debug-unit sequencer. Walks the register file through its
//               debug read port and streams every 32-bit word MSB-first as
//               bytes over a valid/ready interface to the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module du_regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_halted,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_du_reg_addr,
  input  logic [DATA_W-1:0] i_du_reg_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_idx;
  logic [1:0]          r_byte_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_abort;
  logic                r_done;

  logic                w_hs;
  logic                w_last_byte;
  logic                w_abort_req;
  logic                w_done;

  // Handshake and abort qualifiers shared by next-state and datapath logic.
  // An abort seen while a byte is stalled is remembered in r_abort so the
  // byte can still finish before the dump stops.
  assign w_hs        = (r_state == ST_SEND) && i_tx_ready;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_abort_req = i_abort || r_abort;
  assign w_done      = w_hs && w_last_byte && (r_idx == c_last_idx) && !w_abort_req;

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start && i_halted) begin
          w_state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_abort) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_hs) begin
          if (w_abort_req) begin
            w_state_next = ST_IDLE;
          end else if (w_last_byte) begin
            w_state_next = (r_idx == c_last_idx) ? ST_IDLE : ST_ADDR;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register plus index, byte counter, shift register and done pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_byte_cnt <= 2'd0;
      r_shift    <= '0;
      r_abort    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done;
      case (r_state)
        ST_IDLE: begin
          if (i_start && i_halted) begin
            r_idx   <= '0;
            r_abort <= 1'b0;
          end
        end
        ST_ADDR: begin
          r_shift    <= i_du_reg_data;
          r_byte_cnt <= 2'd0;
          r_abort    <= 1'b0;
        end
        ST_SEND: begin
          if (w_hs) begin
            r_shift    <= r_shift << 8;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte && !w_abort_req && (r_idx != c_last_idx)) begin
              r_idx <= r_idx + ADDR_W'(1);
            end
          end else if (i_abort) begin
            r_abort <= 1'b1;
          end
        end
        default: begin
          r_abort <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only, so o_tx_valid never
  // depends on i_tx_ready.
  assign o_du_reg_addr = r_idx;
  assign o_tx_valid    = (r_state == ST_SEND);
  assign o_tx_data     = o_tx_valid ? r_shift[DATA_W-1 -: 8] : 8'd0;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = r_done;

endmodule
`default_nettype wire

// File: doc/du_regfile_dump.md
# du_regfile_dump

Debug-unit sequencer that reads the ID-stage register file through its debug read port and streams the contents out as bytes. When started, it walks register addresses 0..NUM_REGS-1 on the debug address port and captures each 32-bit word. Each word is sent MSB-first over a valid/ready byte interface to the UART transmitter. It sits between the debug unit's command decoder and the UART TX, and runs only while the pipeline is halted.

## Interface
- NUM_REGS, 32, number of registers dumped, starting at address 0
- ADDR_W, 5, width of the debug register address
- DATA_W, 32, register width; fixed at 4 bytes
- i_clk  in  1  clock; all state changes on the rising edge
- i_reset  in  1  reset; synchronous, active-high
- i_start  in  1  dump request; one-cycle pulse, level also tolerated
- i_halted  in  1  pipeline halted; a start is accepted only when this is 1
- i_abort  in  1  cancel request, taken at the next byte boundary
- o_du_reg_addr  out  ADDR_W  register-file debug read address
- i_du_reg_data  in  DATA_W  register-file debug read data, combinational from the address
- o_tx_data  out  8  byte to transmit
- o_tx_valid  out  1  o_tx_data is valid
- i_tx_ready  in  1  UART TX accepts the byte this cycle
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse after the last byte of the last register is accepted

## Operation
- States:
  - IDLE
  - ADDR: drive o_du_reg_addr = idx; at the edge, shift <= i_du_reg_data, byte_cnt <= 0.
  - SEND: o_tx_valid = 1, o_tx_data = shift[31:24].
- IDLE -> ADDR when i_start & i_halted. On entry, idx <= 0.
  - i_start with i_halted = 0 is ignored; no error is signalled.
- SEND handshake: on an edge with i_tx_ready = 1, shift <<= 8 and byte_cnt += 1.
  - byte_cnt is 2 bits and wraps to 0 after the 4th byte.
- After the 4th handshake of a register:
  - idx == NUM_REGS-1: go to IDLE and pulse o_done.
  - otherwise: idx += 1 and go to ADDR.
- Abort: i_abort sampled in ADDR -> IDLE. Sampled in SEND -> the current byte still completes its handshake, then IDLE. o_done is not pulsed on abort.
- i_start while o_busy = 1 is ignored.
- Byte order: register 0 first. Within a register, bits [31:24], [23:16], [15:8], [7:0].
- o_busy = 1 in ADDR and SEND, 0 in IDLE.
- o_du_reg_addr holds idx in every state; it is 0 in IDLE after reset.
- o_tx_data is don't-care when o_tx_valid = 0; the implementation drives 0.

## Timing
- Reset values: state IDLE, idx 0, byte_cnt 0, shift 0, o_du_reg_addr 0, o_tx_data 0, o_tx_valid 0, o_busy 0, o_done 0.
- i_reset overrides every other input on the same edge, including mid-handshake. o_tx_valid is 0 in the cycle after the reset edge.
- Valid/ready rules:
  - once o_tx_valid rises, it and o_tx_data hold stable until an edge with i_tx_ready = 1;
  - o_tx_valid never depends combinationally on i_tx_ready.
- i_halted is checked only at start; deasserting it mid-dump has no effect.
- Latency with i_start accepted at edge 0:
  - cycle 1: ADDR, addr 0;
  - cycles 2-5: SEND.
- Per register with i_tx_ready held 1: 5 cycles (1 ADDR + 4 SEND).
- Full dump with NUM_REGS = 32 and no backpressure: last handshake in cycle 160; o_done = 1 and o_busy = 0 in cycle 161.
- A new i_start in the o_done cycle (state IDLE) is accepted.
- Captured data reflects the register contents at the ADDR cycle. Writes to the file during a dump are the requester's responsibility; the pipeline being halted guarantees there are none.

## Test plan
- Reset:
  - assert i_reset for 2 cycles with i_start = 1 -> all outputs 0 and no dump starts;
  - release with i_start = 0 -> still idle.
- Full dump, no backpressure:
  - stimulus: reg[i] = i*0x01010101, i_halted = 1, i_tx_ready = 1, i_start pulse;
  - response: 128 bytes 00,00,00,00,01,01,01,01,...,1F,1F,1F,1F; o_du_reg_addr steps 0..31; o_done in cycle 161, exactly once.
- Backpressure:
  - stimulus: reg[1] = 0xDEADBEEF; hold i_tx_ready = 0 for 3 cycles while byte 0xAD is presented;
  - response: o_tx_valid = 1 and o_tx_data = 0xAD stable throughout; stream is DE AD BE EF with no duplicates; o_done is delayed by exactly 3 cycles.
- Ignored starts:
  - i_start with i_halted = 0 -> o_busy stays 0;
  - i_start pulses during a dump -> exactly one dump of 128 bytes.
- Abort:
  - assert i_abort while byte 2 of reg 5 is valid with i_tx_ready = 0; raise i_tx_ready 2 cycles later;
  - response: that byte is accepted once, then IDLE with no more bytes and no o_done;
  - a new start then begins again at reg 0.
- Reset mid-dump:
  - i_reset during SEND of reg 10 -> o_tx_valid = 0 in the next cycle, idx = 0, o_busy = 0;
  - a subsequent start dumps from reg 0.
